// File: rtl/uart_tx_frac.sv
// UART transmitter with fractional baud timing: a phase accumulator advances by BAUD
// every clock and fires a bit tick each time it wraps past CLK_HZ.
module uart_tx_frac #(
  parameter int unsigned CLK_HZ    = 1953125,
  parameter int unsigned BAUD      = 9600,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       busy
);

  // Handshake: a byte transfers on any clk edge where tx_valid && tx_ready;
  // tx_ready is high only in ST_IDLE, so tx_valid during a frame is ignored.
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_e;

  state_e      state_q, state_d;
  logic [31:0] acc_q, acc_d;
  logic [7:0]  shift_q, shift_d;
  logic        par_q, par_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [1:0]  stop_cnt_q, stop_cnt_d;
  logic        tx_q, tx_d;
  logic [32:0] acc_sum;
  logic        tick;

  // One spare bit so acc + BAUD can never wrap before the compare.
  assign acc_sum = {1'b0, acc_q} + 33'(BAUD);
  assign tick    = (state_q != ST_IDLE) && (acc_sum >= 33'(CLK_HZ));

  always_comb begin
    state_d    = state_q;
    acc_d      = 32'd0;
    shift_d    = shift_q;
    par_d      = par_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    tx_d       = tx_q;

    if (state_q != ST_IDLE) begin
      acc_d = tick ? 32'(acc_sum - 33'(CLK_HZ)) : acc_sum[31:0];
    end

    case (state_q)
      ST_IDLE: begin
        if (tx_valid) begin
          shift_d    = tx_data;
          par_d      = (PARITY == 2) ? ~^tx_data : ^tx_data;
          bit_cnt_d  = 3'd0;
          stop_cnt_d = 2'd0;
          tx_d       = 1'b0;
          state_d    = ST_START;
        end
      end
      ST_START: begin
        if (tick) begin
          tx_d      = shift_q[0];
          shift_d   = {1'b0, shift_q[7:1]};
          bit_cnt_d = 3'd0;
          state_d   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (bit_cnt_q == 3'd7) begin
            stop_cnt_d = 2'd0;
            if (PARITY != 0) begin
              tx_d    = par_q;
              state_d = ST_PARITY;
            end else begin
              tx_d    = 1'b1;
              state_d = ST_STOP;
            end
          end else begin
            tx_d      = shift_q[0];
            shift_d   = {1'b0, shift_q[7:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      ST_PARITY: begin
        if (tick) begin
          tx_d       = 1'b1;
          stop_cnt_d = 2'd0;
          state_d    = ST_STOP;
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (stop_cnt_q == 2'(STOP_BITS - 1)) begin
            state_d = ST_IDLE;
          end else begin
            stop_cnt_d = stop_cnt_q + 2'd1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      acc_q      <= 32'd0;
      shift_q    <= 8'd0;
      par_q      <= 1'b0;
      bit_cnt_q  <= 3'd0;
      stop_cnt_q <= 2'd0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      tx_q       <= tx_d;
    end
  end

  assign tx       = tx_q;
  assign tx_ready = (state_q == ST_IDLE);
  assign busy     = !tx_ready;

endmodule
